// File: rtl/alu_pkg.sv
// Shared opcode encodings and handshake FSM states for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1011;
    localparam logic [3:0] OP_SLT = 4'b1110;
    localparam logic [3:0] OP_SEQ = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
// lo/hi present the value the last iteration produces, qualified by done.
module iter_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // acc is the running high product half (MUL) or partial remainder (DIV);
    // quo shifts out multiplier bits (MUL) or shifts in quotient bits (DIV).
    always_comb begin
        sum     = {1'b0, acc} + (quo[0] ? {1'b0, opb} : '0);
        shifted = {acc, quo[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        ge      = (shifted >= {1'b0, opb});
        if (is_div) begin
            nxt_hi = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            nxt_lo = {quo[WIDTH-2:0], ge};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], quo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            quo    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            quo    <= a;
            opb    <= b;
            is_div <= op_div;
            count  <= CW'(WIDTH);
        end else if (busy) begin
            acc   <= nxt_hi;
            quo   <= nxt_lo;
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);
    assign done = (count == CW'(1));
    assign lo   = nxt_lo;
    assign hi   = nxt_hi;

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with valid/ready handshake; MUL/DIV delegated to iter_muldiv.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);

    function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        case (op)
            OP_SUB:  return a - b;
            OP_SHL:  return a << b[SHAMT_W-1:0];
            OP_SHR:  return a >> b[SHAMT_W-1:0];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SEQ:  return {{(WIDTH-1){1'b0}}, (a == b)};
            default: return a + b;
        endcase
    endfunction

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             div_zero;
    logic             start_md;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] single_res;

    assign is_mul     = (ALU_control == OP_MUL);
    assign is_div     = (ALU_control == OP_DIV);
    assign div_zero   = is_div && (src_B == '0);
    assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign start_md   = accept && (is_mul || (is_div && !div_zero));
    assign out_valid  = (state == DONE);
    assign single_res = single_op(ALU_control, src_A, src_B);

    iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_md),
        .op_div (is_div),
        .a      (src_A),
        .b      (src_B),
        .busy   (md_busy),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Accepting in DONE chains straight into the next op for back-to-back throughput.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)                          state_next = start_md ? BUSY : DONE;
                else if (state == DONE && out_ready) state_next = IDLE;
            end
            BUSY: begin
                if (md_done)       state_next = DONE;
                else if (!md_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALU_result  <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (start_md) begin
                ALU_result  <= '0;
                result_hi   <= '0;
                zero        <= 1'b0;
                div_by_zero <= 1'b0;
            end else if (div_zero) begin
                ALU_result  <= '1;
                result_hi   <= src_A;
                zero        <= 1'b0;
                div_by_zero <= 1'b1;
            end else begin
                ALU_result  <= single_res;
                result_hi   <= '0;
                zero        <= (single_res == '0);
                div_by_zero <= 1'b0;
            end
        end else if (state == BUSY && md_done) begin
            ALU_result  <= md_lo;
            result_hi   <= md_hi;
            zero        <= (md_lo == '0);
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and streaming bench for multicycle_alu with a queued expected-result scoreboard.
module tb_multicycle_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_A;
    logic [W-1:0] src_B;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         div_by_zero;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [3:0] stream_ops [14] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA,
                                    4'hB, 4'hE, 4'hF, 4'h6, 4'h7, 4'hC, 4'hD};

    multicycle_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_A       (src_A),
        .src_B       (src_B),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_result  (ALU_result),
        .result_hi   (result_hi),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t           e;
        logic [2*W-1:0] p;
        e = '0;
        p = '0;
        case (op)
            4'b0001: e.res = a - b;
            4'b0010: begin
                p     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.res = p[W-1:0];
                e.hi  = p[2*W-1:W];
            end
            4'b0011: begin
                if (b == 0) begin
                    e.res = '1;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                end
            end
            4'b0100: e.res = a << b[4:0];
            4'b0101: e.res = a >> b[4:0];
            4'b1000: e.res = a & b;
            4'b1001: e.res = a | b;
            4'b1010: e.res = a ^ b;
            4'b1011: e.res = ~(a | b);
            4'b1110: e.res = (a < b) ? 1 : 0;
            4'b1111: e.res = (a == b) ? 1 : 0;
            default: e.res = a + b;
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check(tag, {out_valid, ALU_result, result_hi, zero, div_by_zero},
              {1'b1, e.res, e.hi, e.zero, e.dbz});
    endtask

    // Drives one op and holds it until the accept edge; returns #1 after that edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        in_valid    = 1'b1;
        ALU_control = op;
        src_A       = a;
        src_B       = b;
        sb.push_back(model(op, a, b));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        check("send_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid, counting cycles since the accept edge.
    task automatic get_result(input string tag, output int lat, output logic rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid) rdy_seen = rdy_seen | in_ready;
        end while (!out_valid && lat < 100);
        compare_out(tag);
    endtask

    initial begin
        int   lat;
        logic rdy;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        src_A       = '0;
        src_B       = '0;
        ALU_control = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_state", {in_ready, out_valid, ALU_result, result_hi, zero, div_by_zero},
              {1'b1, 1'b0, 64'h0, 2'b00});
        @(posedge clk);
        #1 reset = 1'b0;

        send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        get_result("add_wrap", lat, rdy);
        check("add_wrap_latency", lat, 1);
        @(posedge clk); #1;

        send(OP_MUL, 32'hFFFF_FFFF, 32'h2);
        get_result("mul_max_x2", lat, rdy);
        check("mul_latency", lat, 33);
        check("mul_busy_in_ready_low", rdy, 0);
        @(posedge clk); #1;

        send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        get_result("mul_mixed", lat, rdy);
        @(posedge clk); #1;

        send(OP_DIV, 32'd100, 32'd7);
        get_result("div_100_7", lat, rdy);
        check("div_latency", lat, 33);
        @(posedge clk); #1;

        send(OP_DIV, 32'd7, 32'd100);
        get_result("div_small_zero_q", lat, rdy);
        @(posedge clk); #1;

        send(OP_DIV, 32'hFFFF_FFFF, 32'd3);
        get_result("div_max_3", lat, rdy);
        @(posedge clk); #1;

        send(OP_DIV, 32'd5, 32'd0);
        get_result("div_by_zero", lat, rdy);
        check("div0_latency", lat, 1);
        @(posedge clk); #1;

        send(OP_DIV, 32'd9, 32'd9);
        get_result("div_clears_dbz", lat, rdy);
        @(posedge clk); #1;

        send(4'b1100, 32'd10, 32'd20);
        get_result("undefined_op_is_add", lat, rdy);
        @(posedge clk); #1;

        // Reset two cycles into a multiply discards it.
        send(OP_MUL, 32'd123, 32'd456);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("reset_mid_mul", {in_ready, out_valid, ALU_result, result_hi, zero, div_by_zero},
              {1'b1, 1'b0, 64'h0, 2'b00});
        @(posedge clk);
        #1 reset = 1'b0;
        send(OP_ADD, 32'd3, 32'd4);
        get_result("add_after_reset", lat, rdy);
        check("add_after_reset_latency", lat, 1);
        @(posedge clk); #1;

        // Backpressure with a queued op waiting behind the held result.
        out_ready = 1'b0;
        send(OP_SHL, 32'd1, 32'd31);
        get_result("shl_1_31", lat, rdy);
        @(posedge clk); #1;
        in_valid    = 1'b1;
        ALU_control = OP_SLT;
        src_A       = 32'd3;
        src_B       = 32'd5;
        sb.push_back(model(OP_SLT, 32'd3, 32'd5));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_%0d", i), {in_ready, out_valid, ALU_result},
                  {1'b0, 1'b1, 32'h8000_0000});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        get_result("slt_after_hold", lat, rdy);
        check("slt_after_hold_latency", lat, 1);
        @(posedge clk); #1;

        // Back-to-back single-cycle ops: one result per cycle.
        for (int i = 0; i < 20; i++) begin
            op = stream_ops[$urandom_range(0, 13)];
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            if (i % 5 == 1) b = $urandom_range(0, 31);
            in_valid    = 1'b1;
            ALU_control = op;
            src_A       = a;
            src_B       = b;
            sb.push_back(model(op, a, b));
            @(negedge clk);
            check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
            if (i > 0) compare_out($sformatf("stream_%0d", i - 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        compare_out("stream_19");
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_stream", {out_valid, in_ready}, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
